// File: rtl/spi_boot_loader.sv
// Boot-loader controller behind the SPI slave byte engine: decodes the command byte,
// then streams LSB-first words into IMEM writes or turns them into IMEM read requests.
module spi_boot_loader #(
    parameter int MEM_WORDS = 512,
    parameter int ADDR_W    = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_prog,
    input  logic              i_csn,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_byte,
    output logic [7:0]        o_tx_byte,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [31:0]       o_mem_wdata,
    output logic              o_mem_re,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_boot_done,
    output logic              o_overflow,
    output logic              o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DONE,
        ERR
    } state_t;

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_WORDS * 4);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [31:0]       txbuf_q, txbuf_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              oor_q, oor_d;
    logic              cap_q, cap_d;
    logic              capok_q, capok_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic [31:0]       wordNext;
    logic [ADDR_W-1:0] addrNext;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            ptr_q   <= '0;
            txbuf_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            oor_q   <= 1'b0;
            cap_q   <= 1'b0;
            capok_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            ptr_q   <= ptr_d;
            txbuf_q <= txbuf_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            oor_q   <= oor_d;
            cap_q   <= cap_d;
            capok_q <= capok_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        ptr_d    = ptr_q;
        txbuf_d  = txbuf_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        oor_d    = 1'b0;
        done_d   = done_q;
        ovf_d    = ovf_q;
        // Read reply lands in the buffer two cycles after the address completes.
        cap_d    = re_q | oor_q;
        capok_d  = re_q;
        wordNext = word_q;
        wordNext[{cnt_q, 3'b000} +: 8] = i_rx_byte;
        addrNext = wordNext[ADDR_W-1:0];

        if (cap_q) begin
            txbuf_d = capok_q ? i_mem_rdata : 32'h0;
        end

        if (i_csn || !i_prog) begin
            state_d = IDLE;
            cnt_d   = '0;
            word_d  = '0;
        end else if (i_rx_valid) begin
            case (state_q)
                IDLE: begin
                    case (i_rx_byte)
                        8'h02: begin
                            state_d = WRITE;
                            ptr_d   = '0;
                            done_d  = 1'b0;
                            ovf_d   = 1'b0;
                        end
                        8'h01: begin
                            state_d = READ;
                            txbuf_d = '0;
                        end
                        default: state_d = ERR;
                    endcase
                end
                WRITE: begin
                    cnt_d  = cnt_q + 2'd1;
                    word_d = wordNext;
                    if (cnt_q == 2'd3) begin
                        if (wordNext == 32'hFFFF_FFFF) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            if (ptr_q < LIMIT) begin
                                we_d    = 1'b1;
                                addr_d  = ptr_q;
                                wdata_d = wordNext;
                            end else begin
                                ovf_d = 1'b1;
                            end
                            ptr_d = ptr_q + ADDR_W'(4);
                        end
                    end
                end
                READ: begin
                    cnt_d  = cnt_q + 2'd1;
                    word_d = wordNext;
                    if (cnt_q == 2'd3) begin
                        if (addrNext < LIMIT) begin
                            re_d   = 1'b1;
                            addr_d = {addrNext[ADDR_W-1:2], 2'b00};
                        end else begin
                            oor_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are suppressed the moment PROG drops so the CPU never sees a stray access.
    assign o_mem_we    = we_q & i_prog;
    assign o_mem_re    = re_q & i_prog;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_boot_done = done_q;
    assign o_overflow  = ovf_q;
    assign o_busy      = (state_q != IDLE);
    assign o_tx_byte   = (state_q == READ) ? txbuf_q[{cnt_q, 3'b000} +: 8] : 8'h00;

endmodule
